mdio_master: RTL and testbench

- IEEE 802.3 Clause 22 MDIO management master for the Ethernet PHY.
- Sits directly upstream of the IOBUF on the eth_mdio pin and drives eth_mdc. It converts single-register read/write commands from the driver/control logic into serial MDIO frames and returns read data.
- Replaces ad-hoc bit-banging of eth_mdio_o/eth_mdio_t.

---
 rtl/mdio_master.sv | 187 ++++++++++++++++++
 tb/tb_mdio_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// IEEE 802.3 Clause 22 MDIO master: serialises single-register read/write
// commands onto MDC/MDIO and returns read data with a turnaround error flag.
module mdio_master #(
  parameter int unsigned CLK_DIV      = 50,
  parameter int unsigned PREAMBLE_LEN = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error,
  input  logic        eth_mdio_i,
  output logic        eth_mdio_o,
  output logic        eth_mdio_t,
  output logic        eth_mdc
);
  localparam int unsigned FRAME_LEN = PREAMBLE_LEN + 32;
  localparam int unsigned DIV_W     = 9;
  localparam int unsigned BIT_W     = 7;
  localparam int unsigned TA_IDX    = PREAMBLE_LEN + 14;
  localparam int unsigned DATA_IDX  = PREAMBLE_LEN + 16;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [BIT_W-1:0] r_bit;
  logic [62:0]      r_shift;
  logic [14:0]      r_rx;
  logic             r_write;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_ta_err;
  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic [15:0]      r_rsp_rdata;
  logic             r_rsp_error;
  logic             r_mdio_o;
  logic             r_mdio_t;
  logic             r_mdc;

  logic             w_accept;
  logic             w_div_tc;
  logic             w_fall;
  logic             w_last;
  logic             w_gap_done;
  logic [31:0]      w_tail;
  logic [63:0]      w_load;
  logic             w_cmd_ready_nxt;
  logic             w_rsp_valid_nxt;
  logic             w_mdio_o_nxt;
  logic             w_mdio_t_nxt;
  logic             w_mdc_nxt;

  // Reads put ones in the released TA/DATA slots so the line idles high.
  assign w_tail = {2'b01, cmd_write ? 2'b01 : 2'b10, cmd_phy_addr, cmd_reg_addr,
                   cmd_write ? 2'b10 : 2'b11, cmd_write ? cmd_wdata : 16'hFFFF};
  assign w_load = {32'hFFFF_FFFF, w_tail} << (32 - PREAMBLE_LEN);

  assign w_accept   = cmd_valid && r_cmd_ready;
  assign w_div_tc   = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_fall     = (r_state == S_SHIFT) && w_div_tc && r_mdc;
  assign w_last     = w_fall && (r_bit == BIT_W'(FRAME_LEN - 1));
  assign w_gap_done = (r_state == S_GAP) && (r_div == DIV_W'(2 * CLK_DIV - 1));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last)     w_state_nxt = S_GAP;
      S_GAP:   if (w_gap_done) w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_cmd_ready_nxt = r_cmd_ready;
    w_rsp_valid_nxt = 1'b0;
    w_mdio_o_nxt    = r_mdio_o;
    w_mdio_t_nxt    = r_mdio_t;
    w_mdc_nxt       = r_mdc;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cmd_ready_nxt = 1'b0;
          w_mdio_o_nxt    = w_load[63];
          w_mdio_t_nxt    = 1'b0;
          w_mdc_nxt       = 1'b0;
        end
      end
      S_SHIFT: begin
        if (w_div_tc) w_mdc_nxt = ~r_mdc;
        if (w_last) begin
          w_rsp_valid_nxt = 1'b1;
          w_mdio_o_nxt    = 1'b1;
          w_mdio_t_nxt    = 1'b1;
        end else if (w_fall) begin
          w_mdio_o_nxt = r_shift[62];
          if (!r_write && (r_bit == BIT_W'(TA_IDX - 1))) w_mdio_t_nxt = 1'b1;
        end
      end
      S_GAP: begin
        if (w_gap_done) w_cmd_ready_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers, divider/bit counters, shifters and input synchroniser
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
      r_mdio_o    <= 1'b1;
      r_mdio_t    <= 1'b1;
      r_mdc       <= 1'b0;
      r_div       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_rx        <= '0;
      r_write     <= 1'b0;
      r_ta_err    <= 1'b0;
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
    end else begin
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_mdio_o    <= w_mdio_o_nxt;
      r_mdio_t    <= w_mdio_t_nxt;
      r_mdc       <= w_mdc_nxt;
      r_sync1     <= eth_mdio_i;
      r_sync2     <= r_sync1;
      case (r_state)
        S_IDLE: begin
          r_div <= '0;
          if (w_accept) begin
            r_bit    <= '0;
            r_shift  <= w_load[62:0];
            r_write  <= cmd_write;
            r_rx     <= '0;
            r_ta_err <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_div <= w_div_tc ? '0 : r_div + DIV_W'(1);
          if (w_fall) begin
            r_bit   <= r_bit + BIT_W'(1);
            r_shift <= {r_shift[61:0], 1'b1};
            if (r_bit == BIT_W'(TA_IDX + 1)) r_ta_err <= r_sync2;
            if (r_bit >= BIT_W'(DATA_IDX))   r_rx     <= {r_rx[13:0], r_sync2};
          end
          if (w_last) begin
            r_rsp_rdata <= r_write ? 16'h0000 : {r_rx, r_sync2};
            r_rsp_error <= r_write ? 1'b0 : r_ta_err;
          end
        end
        S_GAP: r_div <= r_div + DIV_W'(1);
        default: r_div <= '0;
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_error  = r_rsp_error;
  assign eth_mdio_o = r_mdio_o;
  assign eth_mdio_t = r_mdio_t;
  assign eth_mdc    = r_mdc;
endmodule

// File: tb/tb_mdio_master.sv
// Directed scoreboard bench for mdio_master: one instance at CLK_DIV=4/PREAMBLE=32,
// one at CLK_DIV=3/PREAMBLE=1, with a simple PHY model on the first.
module tb_mdio_master;
  localparam int unsigned T      = 10;
  localparam int unsigned D1     = 4;
  localparam int unsigned P1     = 32;
  localparam int unsigned N1     = P1 + 32;
  localparam int unsigned D2     = 3;
  localparam int unsigned P2     = 1;
  localparam int unsigned N2     = P2 + 32;
  localparam int unsigned BUDGET = 3000;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int unsigned lat;
  } exp_t;

  logic        clock;
  logic        rst_n;
  logic        v1, v2;
  logic        cmd_write;
  logic [4:0]  cmd_phy, cmd_reg;
  logic [15:0] cmd_wdata;
  logic        rdy1, rv1, err1, o1, t1, mdc1, i1;
  logic        rdy2, rv2, err2, o2, t2, mdc2, i2;
  logic [15:0] rd1, rd2;

  exp_t        sb[$];
  int unsigned n_checks, n_err;
  time         t_acc, t_rsp;
  int unsigned nbs, nb_mark;

  logic [63:0] cap1 = '0, tcap1 = '0, cap2 = '0;
  int unsigned nb1 = 0, nb2 = 0, k1 = 0;
  logic        phy_present;
  logic [15:0] phy_data;
  logic        phy_out = 1'b1;
  bit          seen2 = 1'b0;
  time         t_r2 = 0;
  time         hi_min2 = 64'hFFFF_FFFF, hi_max2 = 0, per_min2 = 64'hFFFF_FFFF, per_max2 = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign i1 = t1 ? phy_out : o1;
  assign i2 = t2 ? 1'b1 : o2;

  mdio_master #(.CLK_DIV(D1), .PREAMBLE_LEN(P1)) u_dut1 (
    .clock(clock), .reset(rst_n), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_write(cmd_write),
    .cmd_phy_addr(cmd_phy), .cmd_reg_addr(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_error(err1),
    .eth_mdio_i(i1), .eth_mdio_o(o1), .eth_mdio_t(t1), .eth_mdc(mdc1));

  mdio_master #(.CLK_DIV(D2), .PREAMBLE_LEN(P2)) u_dut2 (
    .clock(clock), .reset(rst_n), .cmd_valid(v2), .cmd_ready(rdy2), .cmd_write(cmd_write),
    .cmd_phy_addr(cmd_phy), .cmd_reg_addr(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_error(err2),
    .eth_mdio_i(i2), .eth_mdio_o(o2), .eth_mdio_t(t2), .eth_mdc(mdc2));

  // Bit capture on MDC rise; the PHY drives TA0 and read data MSB first on the same edge
  always @(posedge mdc1) begin
    k1    = nb1 - nbs;
    cap1  = {cap1[62:0], o1};
    tcap1 = {tcap1[62:0], t1};
    nb1   = nb1 + 1;
    if (phy_present && k1 == P1 + 15)
      phy_out = 1'b0;
    else if (phy_present && k1 >= P1 + 16 && k1 < P1 + 32)
      phy_out = phy_data[4'(15 - (k1 - (P1 + 16)))];
    else
      phy_out = 1'b1;
  end

  always @(posedge mdc2) begin
    if (seen2) begin
      if ($time - t_r2 < per_min2) per_min2 = $time - t_r2;
      if ($time - t_r2 > per_max2) per_max2 = $time - t_r2;
    end
    t_r2  = $time;
    seen2 = 1'b1;
    cap2  = {cap2[62:0], o2};
    nb2   = nb2 + 1;
  end

  always @(negedge mdc2) begin
    if (seen2) begin
      if ($time - t_r2 < hi_min2) hi_min2 = $time - t_r2;
      if ($time - t_r2 > hi_max2) hi_max2 = $time - t_r2;
    end
  end

  function automatic logic [63:0] frame(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                                        input logic [15:0] wd, input int unsigned pre);
    logic [31:0] tail;
    logic [63:0] f;
    tail = {2'b01, wr ? 2'b01 : 2'b10, phy, rg, wr ? 2'b10 : 2'b11, wr ? wd : 16'hFFFF};
    f    = {32'hFFFF_FFFF, tail};
    return f & ((64'd1 << (pre + 32)) - 64'd1);
  endfunction

  function automatic logic rdy_of(input int sel);
    return (sel == 2) ? rdy2 : rdy1;
  endfunction
  function automatic logic rv_of(input int sel);
    return (sel == 2) ? rv2 : rv1;
  endfunction
  function automatic int unsigned nb_of(input int sel);
    return (sel == 2) ? nb2 : nb1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input int sel, input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                      input logic [15:0] wd, input logic [15:0] erd, input logic eerr,
                      input int unsigned elat, input bit hold);
    int unsigned c;
    exp_t e;
    cmd_write = wr; cmd_phy = phy; cmd_reg = rg; cmd_wdata = wd;
    if (sel == 2) v2 = 1'b1; else v1 = 1'b1;
    c = 0;
    while (!rdy_of(sel) && c < BUDGET) begin @(negedge clock); c++; end
    chk("accept_wait", 64'(rdy_of(sel)), 64'd1);
    t_acc   = $time;
    nbs     = nb_of(sel);
    e.rdata = erd; e.err = eerr; e.lat = elat;
    sb.push_back(e);
    @(negedge clock);
    if (!hold) begin v1 = 1'b0; v2 = 1'b0; end
  endtask

  task automatic wait_rsp(input int sel, input int unsigned nbits);
    int unsigned c;
    exp_t e;
    c = 0;
    while (!rv_of(sel) && c < BUDGET) begin @(negedge clock); c++; end
    chk("rsp_wait", 64'(rv_of(sel)), 64'd1);
    if (!rv_of(sel)) return;
    if (sb.size() == 0) begin chk("sb_empty", 64'(sb.size()), 64'd1); return; end
    e = sb.pop_front();
    chk("rsp_latency", 64'(($time - t_acc) / T), 64'(e.lat));
    chk("rsp_rdata", 64'((sel == 2) ? rd2 : rd1), 64'(e.rdata));
    chk("rsp_error", 64'((sel == 2) ? err2 : err1), 64'(e.err));
    chk("mdc_rises", 64'(nb_of(sel) - nbs), 64'(nbits));
    t_rsp = $time;
    @(negedge clock);
    chk("rsp_pulse_width", 64'(rv_of(sel)), 64'd0);
  endtask

  initial begin
    int unsigned c;
    n_checks = 0; n_err = 0;
    v1 = 1'b0; v2 = 1'b0; cmd_write = 1'b0; cmd_phy = '0; cmd_reg = '0; cmd_wdata = '0;
    phy_present = 1'b0; phy_data = '0;
    t_acc = 0; t_rsp = 0; nbs = 0; nb_mark = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", 64'(rdy1), 64'd1);
    chk("rst_valid", 64'(rv1), 64'd0);
    chk("rst_rdata", 64'(rd1), 64'd0);
    chk("rst_error", 64'(err1), 64'd0);
    chk("rst_mdio_o", 64'(o1), 64'd1);
    chk("rst_mdio_t", 64'(t1), 64'd1);
    chk("rst_mdc", 64'(mdc1), 64'd0);
    chk("rst_ready2", 64'(rdy2), 64'd1);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);

    // Write phy=1 reg=0 data=0x1140
    send(1, 1'b1, 5'd1, 5'd0, 16'h1140, 16'h0000, 1'b0, 2 * D1 * N1 + 1, 1'b0);
    chk("wr_ready_drop", 64'(rdy1), 64'd0);
    chk("wr_drive_t", 64'(t1), 64'd0);
    chk("wr_first_bit", 64'(o1), 64'd1);
    wait_rsp(1, N1);
    chk("wr_frame", cap1, 64'hFFFF_FFFF_5082_1140);
    chk("wr_mdio_t", tcap1, 64'd0);
    c = 0;
    while (!rdy1 && c < BUDGET) begin @(negedge clock); c++; end
    chk("wr_ready_latency", 64'(($time - t_acc) / T), 64'(2 * D1 * (N1 + 1) + 1));

    // Read phy=1 reg=2 with the PHY returning 0x796D
    phy_present = 1'b1; phy_data = 16'h796D;
    send(1, 1'b0, 5'd1, 5'd2, 16'h0000, 16'h796D, 1'b0, 2 * D1 * N1 + 1, 1'b0);
    wait_rsp(1, N1);
    chk("rd_header", 64'(cap1[63:18]), frame(1'b0, 5'd1, 5'd2, 16'h0, P1) >> 18);
    chk("rd_release", tcap1, 64'h0000_0000_0003_FFFF);

    // Read with no PHY: line pulled up
    phy_present = 1'b0;
    send(1, 1'b0, 5'd7, 5'd1, 16'h0000, 16'hFFFF, 1'b1, 2 * D1 * N1 + 1, 1'b0);
    chk("rdata_hold", 64'(rd1), 64'h796D);
    chk("error_hold", 64'(err1), 64'd0);
    wait_rsp(1, N1);

    // Reset in bit 40 of a read aborts it
    phy_present = 1'b1;
    send(1, 1'b0, 5'd1, 5'd2, 16'h0000, 16'h796D, 1'b0, 2 * D1 * N1 + 1, 1'b0);
    c = 0;
    while ((nb1 - nbs) < 41 && c < BUDGET) begin @(negedge clock); c++; end
    chk("abort_at_bit40", 64'(nb1 - nbs), 64'd41);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 64'(rdy1), 64'd1);
    chk("abort_rdata", 64'(rd1), 64'd0);
    chk("abort_error", 64'(err1), 64'd0);
    chk("abort_mdio_o", 64'(o1), 64'd1);
    chk("abort_mdio_t", 64'(t1), 64'd1);
    chk("abort_mdc", 64'(mdc1), 64'd0);
    void'(sb.pop_back());
    repeat (3) begin
      @(negedge clock);
      chk("abort_no_valid", 64'(rv1), 64'd0);
    end
    rst_n = 1'b1;
    phy_present = 1'b0;
    @(negedge clock);
    send(1, 1'b1, 5'd1, 5'd0, 16'h1140, 16'h0000, 1'b0, 2 * D1 * N1 + 1, 1'b0);
    wait_rsp(1, N1);
    chk("post_abort_frame", cap1, 64'hFFFF_FFFF_5082_1140);

    // Back-to-back writes with cmd_valid held high
    send(1, 1'b1, 5'd3, 5'd4, 16'hA5A5, 16'h0000, 1'b0, 2 * D1 * N1 + 1, 1'b1);
    cmd_phy = 5'd5; cmd_reg = 5'd6; cmd_wdata = 16'h0F0F;
    wait_rsp(1, N1);
    chk("hold_first_frame", cap1, frame(1'b1, 5'd3, 5'd4, 16'hA5A5, P1));
    nb_mark = nb1;
    send(1, 1'b1, 5'd5, 5'd6, 16'h0F0F, 16'h0000, 1'b0, 2 * D1 * N1 + 1, 1'b0);
    chk("hold_gap_cycles", 64'((t_acc - t_rsp) / T), 64'(2 * D1));
    chk("hold_gap_no_mdc", 64'(nbs - nb_mark), 64'd0);
    wait_rsp(1, N1);
    chk("hold_second_frame", cap1, frame(1'b1, 5'd5, 5'd6, 16'h0F0F, P1));

    // Short preamble, minimum divider
    send(2, 1'b1, 5'h1F, 5'h15, 16'hBEEF, 16'h0000, 1'b0, 2 * D2 * N2 + 1, 1'b0);
    wait_rsp(2, N2);
    chk("short_frame", 64'(cap2[32:0]), frame(1'b1, 5'h1F, 5'h15, 16'hBEEF, P2));
    chk("short_mdc_high_min", 64'(hi_min2 / T), 64'(D2));
    chk("short_mdc_high_max", 64'(hi_max2 / T), 64'(D2));
    chk("short_mdc_period_min", 64'(per_min2 / T), 64'(2 * D2));
    chk("short_mdc_period_max", 64'(per_max2 / T), 64'(2 * D2));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
